// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Pipelined signed add/subtract unit. The operands are split into GROUP-bit slices, and each
// pipeline stage resolves one slice with a GROUP-bit carry-lookahead adder. The slice carry,
// the partial sum and the operand bits still to be added travel down the pipe together.
// Valid/ready handshakes are used on both sides; a full pipe with out_ready high accepts and
// emits on the same edge, so throughput is one result per cycle.
//
// Latency is NSTG = WIDTH/GROUP clock edges from the accept edge to out_valid: the accept edge
// loads stage 0, and the last stage's registers are the output registers.
//
// Optional feature (compile-time macro ADDSUB_SAT_EN):
//   defined   - on signed overflow the result clamps to the largest/smallest signed value and
//               sat is set; zero/neg follow the clamped value, ovf/cout follow the raw result.
//   undefined - no clamp logic, the result wraps mod 2^WIDTH and sat is tied 0.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of GROUP and >= GROUP
//   GROUP  bits per CLA slice (= bits resolved per stage)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid
//   in_ready   unit can accept this cycle (combinational from out_ready)
//   a, b       two's complement operands
//   cin        carry-in (add) / borrow-in (sub)
//   op_sub     0: a + b + cin, 1: a - b - cin
//   out_valid  result bundle valid
//   out_ready  downstream accepts the result
//   sum        result
//   cout       raw carry out of the MSB slice (sub: 1 = no borrow)
//   ovf        signed overflow of the unsaturated result
//   zero       sum == 0
//   neg        sum[WIDTH-1]
//   sat        saturation applied
// ---------------------------------------------------------------------------------------------

module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             sat
);

    localparam int NSTG = int'(WIDTH / GROUP);

    // GROUP-bit carry-lookahead slice. Every internal carry is formed directly from the
    // generate/propagate terms and the slice carry-in, with no ripple between bit positions.
    // Returns {carry_out, sum_bits}.
    function automatic logic [GROUP:0] cla_slice(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             c_in);
        logic [GROUP-1:0] gen;
        logic [GROUP-1:0] prop;
        logic [GROUP:0]   carry;
        logic             term;
        logic             prod;
        gen      = x & y;
        prop     = x ^ y;
        carry    = '0;
        carry[0] = c_in;
        for (int i = 0; i < int'(GROUP); i++) begin
            // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_in
            term = gen[i];
            prod = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & gen[j]);
                prod = prod & prop[j];
            end
            carry[i+1] = term | (prod & c_in);
        end
        return {carry[GROUP], prop ^ carry[GROUP-1:0]};
    endfunction

    // Pipeline registers, one entry per stage. The last entry of the data arrays only mirrors
    // what the output registers hold and is otherwise not consumed.
    logic [NSTG-1:0]  stg_valid;
    logic [WIDTH-1:0] stg_a    [NSTG];
    logic [WIDTH-1:0] stg_b    [NSTG];   // already conditioned operand B'
    logic [WIDTH-1:0] stg_sum  [NSTG];   // slices 0..k resolved
    logic             stg_carry[NSTG];

    // Values presented to each stage's slice adder (from the inputs or the previous stage).
    logic [WIDTH-1:0] cur_a    [NSTG];
    logic [WIDTH-1:0] cur_b    [NSTG];
    logic [WIDTH-1:0] cur_sum  [NSTG];
    logic             cur_carry[NSTG];
    logic [NSTG-1:0]  up_valid;

    // Results of each stage's slice adder.
    logic [WIDTH-1:0] nxt_sum  [NSTG];
    logic             nxt_carry[NSTG];
    logic [GROUP:0]   slice_res;

    // Flow control.
    logic [NSTG-1:0]  adv;      // stage k would hand its contents on this edge
    logic [NSTG-1:0]  load_en;  // stage k can take new contents this edge

    // Final-stage result and flags.
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             raw_ovf;
    logic             res_sat;
    logic             a_msb;
    logic             b_msb;

    // -----------------------------------------------------------------------------------------
    // Operand conditioning and stage input selection
    // -----------------------------------------------------------------------------------------
    always_comb begin
        // Subtraction is A + ~B + (1 ^ cin): the borrow-in cancels the +1 of the negation.
        cur_a[0]     = a;
        cur_b[0]     = op_sub ? ~b : b;
        cur_sum[0]   = '0;
        cur_carry[0] = op_sub ^ cin;
        up_valid[0]  = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            cur_a[k]     = stg_a[k-1];
            cur_b[k]     = stg_b[k-1];
            cur_sum[k]   = stg_sum[k-1];
            cur_carry[k] = stg_carry[k-1];
            up_valid[k]  = stg_valid[k-1];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Per-stage slice adders: stage k resolves bits [k*GROUP +: GROUP]
    // -----------------------------------------------------------------------------------------
    always_comb begin
        slice_res = '0;
        for (int k = 0; k < NSTG; k++) begin
            slice_res    = cla_slice(cur_a[k][k*GROUP +: GROUP],
                                     cur_b[k][k*GROUP +: GROUP],
                                     cur_carry[k]);
            nxt_sum[k]   = cur_sum[k];
            nxt_sum[k][k*GROUP +: GROUP] = slice_res[GROUP-1:0];
            nxt_carry[k] = slice_res[GROUP];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Flow control: a stage advances iff its successor is empty or itself advancing; the last
    // stage advances on out_ready. This gives a combinational out_ready -> in_ready path so a
    // full pipe never inserts a bubble.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        adv           = '0;
        adv[NSTG-1]   = out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            adv[k] = !stg_valid[k+1] || adv[k+1];
        end
        load_en  = ~stg_valid | adv;
        in_ready = load_en[0];
    end

    // -----------------------------------------------------------------------------------------
    // Pipeline registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 0; k < NSTG; k++) begin
                stg_a[k]     <= '0;
                stg_b[k]     <= '0;
                stg_sum[k]   <= '0;
                stg_carry[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (load_en[k]) begin
                    stg_valid[k] <= up_valid[k];
                    // Data only moves with a valid token; bubbles leave old contents in place.
                    if (up_valid[k]) begin
                        stg_a[k]     <= cur_a[k];
                        stg_b[k]     <= cur_b[k];
                        stg_sum[k]   <= nxt_sum[k];
                        stg_carry[k] <= nxt_carry[k];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Final stage: flags from the full result, optional clamp
    // -----------------------------------------------------------------------------------------
    always_comb begin
        raw_sum = nxt_sum[NSTG-1];
        a_msb   = cur_a[NSTG-1][WIDTH-1];
        b_msb   = cur_b[NSTG-1][WIDTH-1];
        // Operands of equal sign producing a result of the other sign.
        raw_ovf = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
        // Overflow direction follows the sign of A (both operands share it).
        if (raw_ovf) begin
            res_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            res_sat = 1'b1;
        end else begin
            res_sum = raw_sum;
            res_sat = 1'b0;
        end
`else
        res_sum = raw_sum;
        res_sat = 1'b0;
`endif
    end

    // Output registers hold the last result until a new one is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
            sat  <= 1'b0;
        end else if (load_en[NSTG-1] && up_valid[NSTG-1]) begin
            sum  <= res_sum;
            cout <= nxt_carry[NSTG-1];
            ovf  <= raw_ovf;
            zero <= (res_sum == '0);
            neg  <= res_sum[WIDTH-1];
            sat  <= res_sat;
        end
    end

    assign out_valid = stg_valid[NSTG-1];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

    localparam int W    = 16;
    localparam int NSTG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          op_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout, ovf, zero, neg, sat;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic        sat;
    } res_t;

    res_t exp_q[$];

    pipelined_cla_addsub #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic res_t mk(logic [15:0] s, logic c, logic o, logic z, logic n, logic t);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = o; r.zero = z; r.neg = n; r.sat = t;
        return r;
    endfunction

    // Reference: plain integer arithmetic on the signed/unsigned values.
    function automatic res_t model(logic [15:0] x, logic [15:0] y, logic c, logic s);
        int   sx, sy, full;
        res_t r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            full   = sx + sy + int'(c);
            r.cout = (int'(x) + int'(y) + int'(c)) > 65535;
        end else begin
            full   = sx - sy - int'(c);
            r.cout = int'(x) >= (int'(y) + int'(c));   // no borrow
        end
        r.ovf = (full > 32767) || (full < -32768);
        r.sum = full[15:0];
        r.sat = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (r.ovf) begin
            r.sat = 1'b1;
            r.sum = (full > 0) ? 16'h7FFF : 16'h8000;
        end
`endif
        r.zero = (r.sum == 16'h0000);
        r.neg  = r.sum[15];
        return r;
    endfunction

    // One clock cycle: drive, sample at negedge, track transfers, return to posedge+1.
    task automatic step(input logic iv, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic xs, input logic ordy,
                        output logic acc, output logic rdy, output logic got,
                        output logic empty, output res_t obs, output res_t expv);
        in_valid = iv; a = xa; b = xb; cin = xc; op_sub = xs; out_ready = ordy;
        @(negedge clk);
        rdy   = in_ready;
        acc   = iv && in_ready;
        got   = out_valid && ordy;
        empty = 1'b0;
        obs   = {sum, cout, ovf, zero, neg, sat};
        expv  = '0;
        if (got) begin
            if (exp_q.size() == 0) empty = 1'b1;
            else expv = exp_q.pop_front();
        end
        if (acc) exp_q.push_back(model(xa, xb, xc, xs));
        @(posedge clk);
        #1;
    endtask

    // Issue a single op and wait (bounded) for its result; garbage on idle inputs.
    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                          input logic xs, output res_t obs, output res_t expv,
                          output int lat, output logic empty);
        logic acc, rdy, got, emp;
        res_t o, e;
        lat = -1; obs = '0; expv = '0; empty = 1'b0;
        step(1'b1, xa, xb, xc, xs, 1'b1, acc, rdy, got, emp, o, e);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                 acc, rdy, got, emp, o, e);
            if (got) begin
                lat = i; obs = o; expv = e; empty = emp;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic acc, rdy, got, emp;
        res_t o, e;
        int   spurious;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake: got out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
        n_checks++;
        if ({sum, cout, ovf, zero, neg, sat} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {sum, cout, ovf, zero, neg, sat});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        // One result reaches the output, three more in flight.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0, 1'b1,
                 acc, rdy, got, emp, o, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midstream_reset_handshake: got out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
        n_checks++;
        if ({sum, cout, ovf, zero, neg, sat} !== 21'd0) begin
            n_fail++;
            $display("FAIL midstream_reset_outputs: got %h required 0",
                     {sum, cout, ovf, zero, neg, sat});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1,
                 acc, rdy, got, emp, o, e);
            if (got) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d results required 0", spurious);
        end
    endtask

    task automatic test_add();
        res_t o, e;
        int   lat;
        logic emp;
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, o, e, lat, emp);
        n_checks++;
        if (lat != NSTG) begin
            n_fail++;
            $display("FAIL add_latency: got %0d required %0d", lat, NSTG);
        end
        n_checks++;
        if (o !== mk(16'h2234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL add_result: got %h required %h", o,
                     mk(16'h2234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        n_checks++;
        if (emp || o !== e) begin
            n_fail++;
            $display("FAIL add_model: got %h required %h (empty=%b)", o, e, emp);
        end
    endtask

    task automatic test_sub_borrow();
        res_t o, e;
        int   lat;
        logic emp;
        run_op(16'h0005, 16'h0005, 1'b0, 1'b1, o, e, lat, emp);
        n_checks++;
        if (lat != NSTG || o !== mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL sub_zero: got %h lat %0d required %h lat %0d", o, lat,
                     mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), NSTG);
        end
        run_op(16'h0005, 16'h0005, 1'b1, 1'b1, o, e, lat, emp);
        n_checks++;
        if (lat != NSTG || o !== mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h lat %0d required %h lat %0d", o, lat,
                     mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), NSTG);
        end
        n_checks++;
        if (emp || o !== e) begin
            n_fail++;
            $display("FAIL sub_model: got %h required %h", o, e);
        end
    endtask

    task automatic test_overflow();
        res_t o, e, want;
        int   lat;
        logic emp;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, o, e, lat, emp);
`ifdef ADDSUB_SAT_EN
        want = mk(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        want = mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        n_checks++;
        if (o !== want) begin
            n_fail++;
            $display("FAIL ovf_pos: got %h required %h", o, want);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, o, e, lat, emp);
`ifdef ADDSUB_SAT_EN
        want = mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
`else
        want = mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        n_checks++;
        if (o !== want) begin
            n_fail++;
            $display("FAIL ovf_neg: got %h required %h", o, want);
        end
        n_checks++;
        if (emp || o !== e) begin
            n_fail++;
            $display("FAIL ovf_model: got %h required %h", o, e);
        end
    endtask

    task automatic test_back_pressure();
        logic acc, rdy, got, emp, iv, ordy;
        res_t o, e;
        int   issued, recvd, stall_low, bad;
        issued = 0; recvd = 0; stall_low = 0; bad = 0;
        for (int c = 0; c < 40 && recvd < 8; c++) begin
            iv   = issued < 8;
            ordy = !(c >= 5 && c <= 9);
            step(iv, 16'(issued * 16'h0123), 16'h0011, 1'b0, 1'b0, ordy,
                 acc, rdy, got, emp, o, e);
            if (acc) issued++;
            if (iv && !rdy) stall_low++;
            if (c == 7) begin
                n_checks++;
                if (rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_full_in_ready: got %b required 0", rdy);
                end
            end
            if (got) begin
                recvd++;
                n_checks++;
                if (emp || o !== e) begin
                    n_fail++;
                    bad++;
                    $display("FAIL bp_result %0d: got %h required %h (empty=%b)",
                             recvd, o, e, emp);
                end
            end
        end
        n_checks++;
        if (recvd != 8 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, %0d pending required 8, 0",
                     recvd, exp_q.size());
        end
        n_checks++;
        if (stall_low == 0) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d not-ready cycles required >0", stall_low);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, rdy, got, emp, iv;
        res_t o, e;
        int   issued, recvd, first_c, last_c, not_ready;
        issued = 0; recvd = 0; first_c = -1; last_c = -1; not_ready = 0;
        exp_q.delete();
        for (int c = 0; c < 200 && recvd < 100; c++) begin
            iv = issued < 100;
            step(iv, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                 acc, rdy, got, emp, o, e);
            if (acc) issued++;
            if (iv && !rdy) not_ready++;
            if (got) begin
                recvd++;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_checks++;
                if (emp || o !== e) begin
                    n_fail++;
                    $display("FAIL stream_result %0d: got %h required %h (empty=%b)",
                             recvd, o, e, emp);
                end
            end
        end
        n_checks++;
        if (recvd != 100) begin
            n_fail++;
            $display("FAIL stream_count: got %0d required 100", recvd);
        end
        n_checks++;
        if (first_c != NSTG || last_c - first_c != 99 || not_ready != 0) begin
            n_fail++;
            $display("FAIL stream_rate: got first=%0d span=%0d stalls=%0d required %0d/99/0",
                     first_c, last_c - first_c, not_ready, NSTG);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_borrow();
        test_overflow();
        test_back_pressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
